pong_match_ctrl: RTL
====================

# pong_match_ctrl

Match sequencer for the pong game. It owns the game-level state machine (idle, serve delay, play, pause, game over), keeps both players' scores and decides who wins. It drives the run-enable and serve strobe that gate the ball/pad logic. It sits between the player controls and the game-logic block: it consumes that block's miss pulses and the slowed game tick, and feeds scores to the score renderer.

## Interface
Parameters:
- WIN_SCORE, 9: score that ends the match; legal range 1..15.
- SERVE_DELAY, 60: game ticks spent in SERVE before the ball is released; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle game-tick strobe, synchronous to clk.
- start  in  1  start button, level; rising edge detected internally.
- pause  in  1  pause button, level; rising edge detected internally.
- miss_left  in  1  one-cycle pulse: ball passed the left pad.
- miss_right  in  1  one-cycle pulse: ball passed the right pad.
- random  in  8  free-running pseudo-random value.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSED=3, OVER=4.
- run  out  1  high only in PLAY; enables ball and pad motion.
- serve  out  1  one-cycle strobe: reposition the ball at centre and launch it.
- serve_dir  out  1  launch direction on serve: 0 = toward left, 1 = toward right.
- score_left  out  4  left player's score.
- score_right  out  4  right player's score.
- winner  out  1  valid in OVER: 0 = left won, 1 = right won.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, run=0, serve=0, serve_dir=0, both scores=0, winner=0, delay counter=0, start/pause edge registers=0.
- Edge detect: start_re = start & ~start_q; pause_re = pause & ~pause_q. The _q registers update every cycle.
- IDLE:
  - start_re → SERVE; scores cleared; serve_dir=random[7]; counter=0.
- SERVE:
  - Each cycle with tick=1 increments the counter.
  - On a tick with counter==SERVE_DELAY-1 → PLAY; serve=1 for exactly that transition cycle; counter=0.
  - pause_re, start_re and misses are ignored.
- PLAY:
  - miss_left alone: score_right+1; serve_dir=0 (serve toward the player who conceded).
  - miss_right alone: score_left+1; serve_dir=1.
  - After a scoring miss: if the new score equals WIN_SCORE → OVER with winner set to the scorer; otherwise → SERVE.
  - miss_left and miss_right in the same cycle: no score change; serve_dir=random[0]; → SERVE.
  - pause_re with no miss → PAUSED. Any miss in the same cycle takes priority and pause_re is dropped.
- PAUSED:
  - run=0; misses ignored.
  - pause_re → PLAY.
  - start_re → IDLE; scores are kept until the next start.
- OVER:
  - run=0; scores and winner held.
  - start_re → SERVE; scores cleared; winner=0; serve_dir=random[7].
- Scores never exceed WIN_SCORE, so no wrap is possible. Score increments are 4-bit unsigned.
- Unused state encodings 5..7 return to IDLE on the next edge.

## Timing
- Input to state change: one clk. A pulse sampled at edge N is reflected in state/score/run after edge N.
- run is a decode of the registered state: high from the edge entering PLAY until the edge leaving it.
- serve is asserted in the first cycle of PLAY, together with run=1. The downstream block must load the ball on serve before applying motion.
- SERVE duration: exactly SERVE_DELAY tick pulses, counted from the first tick strictly after SERVE is entered.
- The start/pause edge is seen one cycle after the input rises. A button held high produces only one event.
- Reset mid-operation (any state, including during the serve strobe): outputs reach reset values immediately and asynchronously. The first post-reset start_re requires start to be low, then high.

## Test plan
- Reset then start pulse, SERVE_DELAY=3, tick every 4 clks → SERVE for 3 ticks; serve=1 for one cycle as state becomes 2; run=1; scores 0/0.
- In PLAY, pulse miss_left → score_right=1, serve_dir=0, state=1 next cycle; after 3 ticks, serve again.
- WIN_SCORE=2: two miss_right events → score_left=2, state=4, winner=0, run=0. Start → scores 0/0, state=1.
- miss_left and miss_right in the same cycle with random[0]=1 → scores unchanged, serve_dir=1, state=1. Same cycle as pause_re → pause ignored.
- Pause toggle: pause_re in PLAY → state=3, run=0, and a miss_right pulse is ignored. pause_re again → state=2 with no serve strobe. Pause held high for 10 clks → only one toggle.
- Assert rst while in SERVE with counter=2 and score 1/1 → outputs reset at once. After release, start still low → remain IDLE.

Source files
------------

// File: rtl/pong_match_ctrl.sv
//------------------------------------------------------------------------------
// pong_match_ctrl: match sequencer (idle/serve/play/pause/over), scores, winner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic [7:0] random,
  output logic [2:0] state,
  output logic       run,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [3:0] WIN       = 4'(WIN_SCORE);
  localparam logic [7:0] LAST_TICK = 8'(SERVE_DELAY - 1);

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] score_left_d, score_right_d;
  logic       winner_d, serve_d, serve_dir_d, run_d;
  logic       start_q, pause_q;
  logic       start_re, pause_re;
  logic       unused_random;

  assign start_re      = start & ~start_q;
  assign pause_re      = pause & ~pause_q;
  assign unused_random = ^random[6:1];
  assign state         = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 8'd0;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      winner      <= 1'b0;
      serve       <= 1'b0;
      serve_dir   <= 1'b0;
      run         <= 1'b0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      score_left  <= score_left_d;
      score_right <= score_right_d;
      winner      <= winner_d;
      serve       <= serve_d;
      serve_dir   <= serve_dir_d;
      run         <= run_d;
      start_q     <= start;
      pause_q     <= pause;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    score_left_d  = score_left;
    score_right_d = score_right;
    winner_d      = winner;
    serve_d       = 1'b0;
    serve_dir_d   = serve_dir;
    case (state_q)
      IDLE: begin
        if (start_re) begin
          state_d       = SERVE;
          count_d       = 8'd0;
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          serve_dir_d   = random[7];
        end
      end
      SERVE: begin
        if (tick) begin
          if (count_q == LAST_TICK) begin
            state_d = PLAY;
            count_d = 8'd0;
            serve_d = 1'b1;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
      end
      PLAY: begin
        // A miss always wins over a pause request in the same cycle.
        if (miss_left && miss_right) begin
          state_d     = SERVE;
          count_d     = 8'd0;
          serve_dir_d = random[0];
        end else if (miss_left) begin
          score_right_d = score_right + 4'd1;
          serve_dir_d   = 1'b0;
          count_d       = 8'd0;
          if (score_right_d == WIN) begin
            state_d  = OVER;
            winner_d = 1'b1;
          end else begin
            state_d = SERVE;
          end
        end else if (miss_right) begin
          score_left_d = score_left + 4'd1;
          serve_dir_d  = 1'b1;
          count_d      = 8'd0;
          if (score_left_d == WIN) begin
            state_d  = OVER;
            winner_d = 1'b0;
          end else begin
            state_d = SERVE;
          end
        end else if (pause_re) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_re) begin
          state_d = PLAY;
        end else if (start_re) begin
          state_d = IDLE;
        end
      end
      OVER: begin
        if (start_re) begin
          state_d       = SERVE;
          count_d       = 8'd0;
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = 1'b0;
          serve_dir_d   = random[7];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    run_d = (state_d == PLAY);
  end

endmodule

`default_nettype wire
